// File: rtl/quant_coeff_loader_pkg.sv
// rtl/quant_coeff_loader_pkg.sv - command/status field positions, widths and FSM states
package quant_coeff_loader_pkg;

    localparam int CMD_TOGGLE_BIT = 31;
    localparam int CMD_FILL_BIT   = 30;
    localparam int CMD_CLR_BIT    = 29;
    localparam int CMD_CNT_LSB    = 16;
    localparam int FILL_W         = 12;

    localparam int ST_BUSY_BIT    = 31;
    localparam int ST_OVR_BIT     = 30;
    localparam int ST_WAIT_BIT    = 29;
    localparam int ST_VFAIL_BIT   = 28;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_WRITE     = 2'd2,
        ST_VERIFY    = 2'd3
    } state_e;

    function automatic logic [31:0] pack_status(input logic busy,
                                                input logic ovr,
                                                input logic waiting,
                                                input logic vfail,
                                                input logic [CNT_W-1:0] cnt);
        logic [31:0] s;
        s               = '0;
        s[ST_BUSY_BIT]  = busy;
        s[ST_OVR_BIT]   = ovr;
        s[ST_WAIT_BIT]  = waiting;
        s[ST_VFAIL_BIT] = vfail;
        s[CNT_W-1:0]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/quant_coeff_loader_cmd_sync.sv
// rtl/quant_coeff_loader_cmd_sync.sv - quant_cmd_sync: register software words, detect commit toggle
module quant_cmd_sync
    import quant_coeff_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int COEF_W = 18
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       cmd_reg,
    input  logic [31:0]       data_reg,
    output logic              commit,
    output logic              fill,
    output logic              clr,
    output logic [FILL_W-1:0] fill_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic [COEF_W-1:0] data
);

    logic [31:0] cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic        tog_q, tog_d;
    logic        unused_bits;

    always_comb begin
        cmd_d  = cmd_reg;
        data_d = data_reg;
        tog_d  = cmd_q[CMD_TOGGLE_BIT];
    end

    // Last-seen toggle tracks the raw input during reset so release never looks like a commit.
    always_ff @(posedge user_clk) begin
        cmd_q  <= cmd_d;
        data_q <= data_d;
        if (user_rst) begin
            tog_q <= cmd_reg[CMD_TOGGLE_BIT];
        end else begin
            tog_q <= tog_d;
        end
    end

    assign commit      = cmd_q[CMD_TOGGLE_BIT] ^ tog_q;
    assign fill        = cmd_q[CMD_FILL_BIT];
    assign clr         = cmd_q[CMD_CLR_BIT];
    assign fill_cnt    = cmd_q[CMD_CNT_LSB +: FILL_W];
    assign addr        = cmd_q[ADDR_W-1:0];
    assign data        = data_q[COEF_W-1:0];
    assign unused_bits = ^{cmd_q, data_q};

endmodule

// File: rtl/quant_coeff_loader.sv
// rtl/quant_coeff_loader.sv - coefficient BRAM write sequencer; optional readback check via QUANT_COEFF_LOADER_VERIFY_EN
module quant_coeff_loader
    import quant_coeff_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int COEF_W    = 18,
    parameter int SYNC_GATE = 1
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       cmd_reg,
    input  logic [31:0]       data_reg,
    input  logic              sync_in,
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
    input  logic [COEF_W-1:0] ram_dout,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [COEF_W-1:0] ram_din,
    output logic [31:0]       status_out
);

    logic              commit, c_fill, c_clr;
    logic [FILL_W-1:0] c_cnt;
    logic [ADDR_W-1:0] c_addr;
    logic [COEF_W-1:0] c_data;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COEF_W-1:0] coef_q, coef_d;
    logic [FILL_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [COEF_W-1:0] ram_din_q, ram_din_d;
    logic [31:0]       status_q, status_d;
    logic              vfail_flag;

`ifdef QUANT_COEFF_LOADER_VERIFY_EN
    logic vfail_q, vfail_d;
    logic vcnt_q, vcnt_d;
    logic cmp_q, cmp_d;
    assign vfail_flag = vfail_q;
`else
    assign vfail_flag = 1'b0;
`endif

    quant_cmd_sync #(
        .ADDR_W (ADDR_W),
        .COEF_W (COEF_W)
    ) u_cmd_sync (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .cmd_reg  (cmd_reg),
        .data_reg (data_reg),
        .commit   (commit),
        .fill     (c_fill),
        .clr      (c_clr),
        .fill_cnt (c_cnt),
        .addr     (c_addr),
        .data     (c_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        coef_d     = coef_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
        vfail_d    = vfail_q;
        vcnt_d     = vcnt_q;
        cmp_d      = 1'b0;
        if (cmp_q && (ram_dout != coef_q)) begin
            vfail_d = 1'b1;
        end
`endif

        // Commits are only accepted when idle; anything else is dropped and flagged.
        if (commit) begin
            if (state_q == ST_IDLE) begin
                addr_d  = c_addr;
                coef_d  = c_data;
                rem_d   = c_fill ? c_cnt : '0;
                state_d = (SYNC_GATE != 0) ? ST_WAIT_SYNC : ST_WRITE;
                if (c_clr) begin
                    ovr_d = 1'b0;
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
                    vfail_d = 1'b0;
`endif
                end
            end else begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT_SYNC: begin
                if (sync_in) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we_d   = 1'b1;
                ram_addr_d = addr_q;
                ram_din_d  = coef_q;
                addr_d     = addr_q + ADDR_W'(1);
                if (rem_q == '0) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
                    state_d = ST_VERIFY;
                    vcnt_d  = 1'b0;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    rem_d = rem_q - FILL_W'(1);
                end
            end
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
            // Two read cycles at the last address; the compare strobe lands when BRAM data is valid.
            ST_VERIFY: begin
                ram_addr_d = addr_q - ADDR_W'(1);
                vcnt_d     = 1'b1;
                if (vcnt_q) begin
                    state_d = ST_IDLE;
                    cmp_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        status_d = pack_status(state_q != ST_IDLE, ovr_q,
                               state_q == ST_WAIT_SYNC, vfail_flag, cnt_q);
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            coef_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            status_q   <= '0;
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
            vfail_q    <= 1'b0;
            vcnt_q     <= 1'b0;
            cmp_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            coef_q     <= coef_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            status_q   <= status_d;
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
            vfail_q    <= vfail_d;
            vcnt_q     <= vcnt_d;
            cmp_q      <= cmp_d;
`endif
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_quant_coeff_loader.sv
// tb/tb_quant_coeff_loader.sv - self-checking bench: ungated and sync-gated loaders side by side
module tb_quant_coeff_loader;

    logic        clk = 1'b0;
    logic        user_rst;
    logic [31:0] cmd0, data0, cmd1, data1;
    logic        sync0, sync1;
    logic        we0, we1;
    logic [9:0]  addr0, addr1;
    logic [17:0] din0, din1;
    logic [31:0] status0, status1;

    int checks = 0;
    int errors = 0;
    int exp_cnt0 = 0;
    logic [27:0] mon0[$];
    logic [27:0] expq[$];

    always #5 clk = ~clk;

`ifdef QUANT_COEFF_LOADER_VERIFY_EN
    localparam int VX = 2;
    logic [17:0] mem0[1024];
    logic [17:0] mem1[1024];
    logic [17:0] dout0, dout1;
    bit          corrupt0 = 1'b0;
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= din0;
        if (we1) mem1[addr1] <= din1;
        dout0 <= mem0[addr0] ^ (corrupt0 ? 18'h00001 : 18'h0);
        dout1 <= mem1[addr1];
    end
`else
    localparam int VX = 0;
`endif

    quant_coeff_loader #(.ADDR_W(10), .COEF_W(18), .SYNC_GATE(0)) dut0 (
        .user_clk(clk), .user_rst(user_rst), .cmd_reg(cmd0), .data_reg(data0),
        .sync_in(sync0),
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
        .ram_dout(dout0),
`endif
        .ram_we(we0), .ram_addr(addr0), .ram_din(din0), .status_out(status0));

    quant_coeff_loader #(.ADDR_W(10), .COEF_W(18), .SYNC_GATE(1)) dut1 (
        .user_clk(clk), .user_rst(user_rst), .cmd_reg(cmd1), .data_reg(data1),
        .sync_in(sync1),
`ifdef QUANT_COEFF_LOADER_VERIFY_EN
        .ram_dout(dout1),
`endif
        .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .status_out(status1));

    always @(negedge clk) begin
        if (we0 === 1'b1) mon0.push_back({addr0, din0});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic commit0(input logic [9:0] a, input logic fill, input logic [11:0] c,
                           input logic [17:0] d, input logic clr);
        data0 = {14'h0, d};
        cmd0  = {~cmd0[31], fill, clr, 1'b0, c, 6'h0, a};
    endtask

    task automatic commit1(input logic [9:0] a, input logic [17:0] d);
        data1 = {14'h0, d};
        cmd1  = {~cmd1[31], 3'b000, 12'h0, 6'h0, a};
    endtask

    task automatic wait_idle0();
        bit ok;
        ok = 1'b0;
        repeat (3) @(negedge clk);
        for (int t = 0; t < 2000; t++) begin
            if (status0[31] == 1'b0 && we0 == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle_timeout", {31'h0, ok}, 32'h1);
    endtask

    typedef struct {
        logic [9:0]  addr;
        logic        fill;
        logic [11:0] cnt;
        logic [17:0] data;
        int          exp_n;
        logic [9:0]  exp_last;
    } vec_t;
    vec_t vecs[5];

    initial begin
        logic [9:0] ea, last;
        vecs[0] = '{10'h005, 1'b0, 12'd0, 18'h1ABCD, 1, 10'h005};
        vecs[1] = '{10'h3FE, 1'b1, 12'd3, 18'h2F00F, 4, 10'h001};
        vecs[2] = '{10'h000, 1'b1, 12'd0, 18'h00001, 1, 10'h000};
        vecs[3] = '{10'h123, 1'b0, 12'd5, 18'h3FFFF, 1, 10'h123};
        vecs[4] = '{10'h3FF, 1'b1, 12'd1, 18'h15555, 2, 10'h000};

        user_rst = 1'b1;
        cmd0 = 32'h0; data0 = 32'h0; sync0 = 1'b0;
        cmd1 = 32'h8000_0000; data1 = 32'h0; sync1 = 1'b0;
        repeat (3) @(negedge clk);
        user_rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_we0", {31'h0, we0}, 32'h0);
        check("rst_addr_din0", {4'h0, addr0, din0}, 32'h0);
        check("rst_status0", status0, 32'h0);
        check("rst_we_status1", {31'h0, we1} | status1, 32'h0);

        // Ungated single writes and fills from the vector table
        foreach (vecs[v]) begin
            commit0(vecs[v].addr, vecs[v].fill, vecs[v].cnt, vecs[v].data, 1'b0);
            exp_cnt0++;
            @(negedge clk);
            @(negedge clk);
            check("latency_we_low", {31'h0, we0}, 32'h0);
            last = 10'h0;
            for (int i = 0; i < vecs[v].exp_n; i++) begin
                @(negedge clk);
                ea = vecs[v].addr + 10'(i);
                check("write", {3'h0, we0, addr0, din0}, {3'h0, 1'b1, ea, vecs[v].data});
                last = addr0;
            end
            check("last_addr", {22'h0, last}, {22'h0, vecs[v].exp_last});
            repeat (VX) @(negedge clk);
            @(negedge clk);
            check("done_idle", {30'h0, we0, status0[31]}, 32'h0);
            check("done_count", {16'h0, status0[15:0]}, exp_cnt0);
        end

        // Gated: sync on the commit cycle ignored, then 20 cycles waiting
        commit1(10'h040, 18'h0BEEF);
        @(negedge clk);
        sync1 = 1'b1;
        @(negedge clk);
        sync1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("wait_sync", {29'h0, we1, status1[31], status1[29]}, 32'h3);
        end
        sync1 = 1'b1;
        @(negedge clk);
        sync1 = 1'b0;
        check("sync_sampled", {30'h0, we1, status1[29]}, 32'h1);
        @(negedge clk);
        check("gated_write", {3'h0, we1, addr1, din1}, {3'h0, 1'b1, 10'h040, 18'h0BEEF});
        check("gated_wait_clear", {31'h0, status1[29]}, 32'h0);
        repeat (VX) @(negedge clk);
        @(negedge clk);
        check("gated_done", status1, 32'h1);
        sync1 = 1'b1;
        @(negedge clk);
        sync1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_sync_ignored", {31'h0, we1} | status1, 32'h1);
        end

        // Overrun: second toggle mid-fill dropped; data change mid-burst ignored
        mon0.delete();
        commit0(10'h100, 1'b1, 12'd7, 18'h11111, 1'b0);
        exp_cnt0++;
        repeat (4) @(negedge clk);
        commit0(10'h200, 1'b0, 12'd0, 18'h22222, 1'b0);
        wait_idle0();
        check("ovr_writes", mon0.size(), 8);
        for (int i = 0; i < mon0.size() && i < 8; i++)
            check("ovr_burst", {4'h0, mon0[i]}, {4'h0, 10'h100 + 10'(i), 18'h11111});
        check("ovr_sticky", {31'h0, status0[30]}, 32'h1);
        commit0(10'h050, 1'b0, 12'd0, 18'h33333, 1'b1);
        exp_cnt0++;
        wait_idle0();
        check("ovr_cleared", {31'h0, status0[30]}, 32'h0);
        check("clr_write", {4'h0, mon0[mon0.size()-1]}, {4'h0, 10'h050, 18'h33333});
        check("ovr_count", {16'h0, status0[15:0]}, exp_cnt0);

        // Randomized commits against a run-list model: N = fill ? count+1 : 1, address wraps mod 1024
        mon0.delete();
        expq.delete();
        for (int r = 0; r < 30; r++) begin
            logic [9:0]  ra;
            logic        rf;
            logic [11:0] rc;
            logic [17:0] rd;
            int          n;
            ra = 10'($urandom_range(0, 1023));
            rf = 1'($urandom_range(0, 1));
            rc = 12'($urandom_range(0, 9));
            rd = 18'($urandom);
            n  = rf ? int'(rc) + 1 : 1;
            for (int i = 0; i < n; i++)
                expq.push_back({10'((int'(ra) + i) % 1024), rd});
            exp_cnt0++;
            commit0(ra, rf, rc, rd, 1'b0);
            wait_idle0();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("rand_len", mon0.size(), expq.size());
        for (int i = 0; i < expq.size() && i < mon0.size(); i++)
            check("rand_write", {4'h0, mon0[i]}, {4'h0, expq[i]});
        check("rand_count", {16'h0, status0[15:0]}, exp_cnt0);

`ifdef QUANT_COEFF_LOADER_VERIFY_EN
        corrupt0 = 1'b1;
        commit0(10'h010, 1'b0, 12'd0, 18'h0AAAA, 1'b0);
        exp_cnt0++;
        wait_idle0();
        repeat (2) @(negedge clk);
        check("verify_fail_set", {31'h0, status0[28]}, 32'h1);
        corrupt0 = 1'b0;
        commit0(10'h011, 1'b0, 12'd0, 18'h05555, 1'b1);
        exp_cnt0++;
        wait_idle0();
        repeat (2) @(negedge clk);
        check("verify_fail_clear", {31'h0, status0[28]}, 32'h0);
`endif

        // Reset mid-fill with the toggle left at 1
        if (cmd0[31] == 1'b1) begin
            commit0(10'h300, 1'b0, 12'd0, 18'h00777, 1'b0);
            wait_idle0();
        end
        commit0(10'h080, 1'b1, 12'd15, 18'h0F0F0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_writing", {31'h0, we0}, 32'h1);
        user_rst = 1'b1;
        @(negedge clk);
        check("reset_we", {31'h0, we0}, 32'h0);
        check("reset_status", status0, 32'h0);
        @(negedge clk);
        user_rst = 1'b0;
        exp_cnt0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_spurious", {31'h0, we0} | status0, 32'h0);
        end
        commit0(10'h0AA, 1'b0, 12'd0, 18'h12345, 1'b0);
        exp_cnt0++;
        wait_idle0();
        check("post_reset_count", {16'h0, status0[15:0]}, exp_cnt0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quant_coeff_loader.md
Name: quant_coeff_loader

Overview:
- Sequences software-initiated writes into a quantizer gain-coefficient BRAM.
- Inputs are two software-register words already in the user clock domain: an address/command word and a data word.
- On a commit (toggle of a command bit), writes one coefficient or fills a run of addresses, optionally aligned to the spectrum frame sync so a spectrum is never quantized with a half-updated table.
- Exposes a status word for a simulink-to-ppc readback register.

Parameters:
- ADDR_W, 10, coefficient RAM address width (1..16).
- COEF_W, 18, coefficient width (1..32).
- SYNC_GATE, 1, 1 = hold writes until next sync_in; 0 = write immediately.

Ports:
- user_clk  in  1  user/DSP clock; all logic on rising edge.
- user_rst  in  1  synchronous, active-high reset.
- cmd_reg  in  32  [31] commit toggle, [30] fill enable, [29] clear errors, [27:16] fill count minus 1, [ADDR_W-1:0] start address.
- data_reg  in  32  [COEF_W-1:0] coefficient value.
- sync_in  in  1  one-cycle frame sync pulse.
- ram_we  out  1  coefficient RAM write enable.
- ram_addr  out  ADDR_W  coefficient RAM address.
- ram_din  out  COEF_W  coefficient RAM write data.
- status_out  out  32  [31] busy, [30] overrun sticky, [29] waiting for sync, [28] verify-fail sticky, [15:0] completed-commit counter.

Behaviour:
- Reset values:
  - ram_we=0, ram_addr=0, ram_din=0, status_out=0, state IDLE.
  - Last-seen toggle loads cmd_reg[31], so no commit fires on reset release.
- Input stage: cmd_reg and data_reg registered once (1 cycle). Commit = registered toggle differs from last-seen toggle; last-seen is updated every cycle.
- Capture on commit in IDLE:
  - Capture addr, data, and remaining = fill ? cmd[27:16] : 0.
  - If cmd[29]=1, clear overrun and verify-fail bits.
- FSM states: IDLE, WAIT_SYNC, WRITE, VERIFY (VERIFY only with the optional feature).
  - IDLE to WAIT_SYNC on commit when SYNC_GATE=1; IDLE to WRITE when SYNC_GATE=0.
  - WAIT_SYNC to WRITE on sync_in=1. A sync coincident with the commit cycle is not consumed; wait for the next sync.
  - WRITE: ram_we=1 every cycle. Address increments modulo 2^ADDR_W (wraps at top). remaining decrements. After the write with remaining==0, go to IDLE (or VERIFY) and increment the commit counter (16-bit, wraps 0xFFFF to 0).
- Latency:
  - Ungated: ram_we first high 3 cycles after cmd_reg toggles (input reg, detect/capture, write).
  - Gated: ram_we high the cycle after sync_in is sampled high in WAIT_SYNC.
  - Fill of N addresses gives exactly N consecutive ram_we cycles.
- Overrun: a commit detected while not IDLE is dropped, not queued, and sets overrun sticky. The toggle is still consumed.
- Busy/wait flags: busy=1 in any state other than IDLE. Bit 29=1 only in WAIT_SYNC.
- sync_in outside WAIT_SYNC is ignored.
- data_reg changes during a burst have no effect; captured data is used.
- Reset mid-burst: ram_we=0 on the next edge, burst abandoned, counter cleared.

Optional Feature:
- Macro: QUANT_COEFF_LOADER_VERIFY_EN.
- With the macro:
  - Adds input ram_dout (COEF_W; BRAM read latency 1).
  - After the last write, VERIFY drives ram_addr to the last written address with ram_we=0 for 2 cycles and compares ram_dout against the captured data.
  - Mismatch sets status[28]. Busy extends by 2 cycles.
- Without the macro: no ram_dout port, no VERIFY state, status[28] tied 0.

Decomposition:
- Package quant_coeff_loader_pkg: cmd/status bit-position constants, fill-count width (12), state enum.
- One natural sub-module, quant_cmd_sync: input registers plus toggle edge detect, output commit pulse and captured fields.

Test Plan:
- SYNC_GATE=0; cmd toggle, addr 0x005, fill=0, data 0x1ABCD -> one ram_we at addr 5, din 0x1ABCD, 3 cycles after toggle; counter=1.
- Fill, addr 0x3FE, count-1=3, ADDR_W=10 -> ram_we 4 cycles at 0x3FE, 0x3FF, 0x000, 0x001; busy clears next cycle.
- SYNC_GATE=1; commit, sync 20 cycles later -> status[29]=1 until sync; ram_we cycle after sync. Sync on the commit cycle is ignored.
- Second toggle mid-fill -> dropped, status[30]=1; next commit with bit29=1 -> status[30]=0.
- user_rst asserted mid-fill -> ram_we=0 next cycle, status=0; no spurious commit after release while cmd_reg[31]=1.
- VERIFY_EN, ram model returns corrupted word -> status[28]=1; correct model -> status[28]=0.
